// File: rtl/image_mem_pkg.sv
// image_mem_pkg: shared widths, writer FSM states and the image-memory request
// bundle used by the writer, the image memory and the read path.
package image_mem_pkg;

    localparam int IMG_ADDR_W = 15;
    localparam int IMG_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        VRD,
        VCMP,
        DONE
    } state_t;

    typedef struct packed {
        logic                  enable;
        logic                  we;
        logic                  re;
        logic [IMG_ADDR_W-1:0] address;
        logic [IMG_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/image_mem_writer.sv
// image_mem_writer: streams valid/ready pixels into consecutive image-memory words.
// Define IMAGE_MEM_WRITER_VERIFY_EN to read back and compare every written word.
module image_mem_writer
    import image_mem_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W,
    parameter int DATA_W = IMG_DATA_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_enable,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              mismatch
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              in_ready_q, in_ready_d;
    mem_req_t          req_q, req_d;
    logic              hs;
    logic              last;
`ifdef IMAGE_MEM_WRITER_VERIFY_EN
    logic              cmp_q, cmp_d;
    logic              mismatch_q, mismatch_d;
`endif

    always_comb begin
        hs           = in_valid & in_ready_q;
        last         = rem_q == LEN_W'(1);
        state_d      = state_q;
        ptr_d        = ptr_q;
        rem_d        = rem_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        in_ready_d   = 1'b0;
        req_d        = req_q;
        req_d.enable = 1'b0;
        req_d.we     = 1'b0;
        req_d.re     = 1'b0;
`ifdef IMAGE_MEM_WRITER_VERIFY_EN
        cmp_d        = 1'b0;
        // read data for the word read in VCMP arrives one cycle later
        mismatch_d   = (cmp_q && mem_rdata != DATA_W'(req_q.wdata)) ? 1'b1 : mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d      = base_addr;
                    rem_d      = length;
                    busy_d     = 1'b1;
                    state_d    = (length == '0) ? DONE : STREAM;
                    in_ready_d = length != '0;
`ifdef IMAGE_MEM_WRITER_VERIFY_EN
                    mismatch_d = 1'b0;
`endif
                end
            end
            STREAM: begin
                if (hs) begin
                    req_d.enable  = 1'b1;
                    req_d.we      = 1'b1;
                    req_d.address = IMG_ADDR_W'(ptr_q);
                    req_d.wdata   = IMG_DATA_W'(in_data);
                    ptr_d         = ptr_q + ADDR_W'(1);
                    rem_d         = rem_q - LEN_W'(1);
                end
`ifdef IMAGE_MEM_WRITER_VERIFY_EN
                in_ready_d = !hs;
                state_d    = hs ? VRD : STREAM;
`else
                in_ready_d = !(hs && last);
                state_d    = (hs && last) ? DONE : STREAM;
`endif
            end
`ifdef IMAGE_MEM_WRITER_VERIFY_EN
            VRD: begin
                req_d.enable = 1'b1;
                req_d.re     = 1'b1;
                state_d      = VCMP;
            end
            VCMP: begin
                cmp_d      = 1'b1;
                in_ready_d = rem_q != '0;
                state_d    = (rem_q == '0) ? DONE : STREAM;
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            req_q      <= '0;
`ifdef IMAGE_MEM_WRITER_VERIFY_EN
            cmp_q      <= 1'b0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            req_q      <= req_d;
`ifdef IMAGE_MEM_WRITER_VERIFY_EN
            cmp_q      <= cmp_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign in_ready         = in_ready_q;
    assign mem_enable       = req_q.enable;
    assign mem_write_enable = req_q.we;
    assign mem_address      = ADDR_W'(req_q.address);
    assign mem_wdata        = DATA_W'(req_q.wdata);
    assign busy             = busy_q;
    assign done             = done_q;

`ifdef IMAGE_MEM_WRITER_VERIFY_EN
    assign mem_read_enable  = req_q.re;
    assign mismatch         = mismatch_q;
`else
    logic unused_rdata;
    assign unused_rdata     = ^{mem_rdata, req_q.re};
    assign mem_read_enable  = 1'b0;
    assign mismatch         = 1'b0;
`endif

endmodule

// File: tb/tb_image_mem_writer.sv
// tb_image_mem_writer: directed checks of image_mem_writer against a behavioural
// image memory that stores 0xBEEF whenever 0x1234 is written.
module tb_image_mem_writer;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [14:0] base_addr;
    logic [15:0] length, in_data;
    logic        in_ready, mem_enable, mem_write_enable, mem_read_enable;
    logic [14:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        busy, done, mismatch;
    logic [15:0] mem [0:32767];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    image_mem_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .mismatch(mismatch)
    );

    always @(posedge clk) begin
        if (mem_enable && mem_write_enable)
            mem[mem_address] <= (mem_wdata == 16'h1234) ? 16'hBEEF : mem_wdata;
        if (mem_enable && mem_read_enable)
            mem_rdata <= mem[mem_address];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_xfer(input logic [14:0] b, input logic [15:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; base_addr = '0; length = '0;
        tick();
        n_cmp++;
        if ({in_ready, mem_enable, mem_write_enable, mem_read_enable, busy, done, mismatch} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 0000000", {in_ready, mem_enable, mem_write_enable, mem_read_enable, busy, done, mismatch});
        end
        n_cmp++;
        if ({mem_address, mem_wdata} !== 31'h0) begin
            n_err++;
            $display("FAIL reset_bus got %h/%h want 0/0", mem_address, mem_data_dummy(mem_wdata));
        end
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [15:0] mem_data_dummy(input logic [15:0] d);
        return d;
    endfunction

    task automatic test_basic();
        start_xfer(15'h0010, 16'd4);
        n_cmp++;
        if ({busy, in_ready, mem_enable} !== 3'b110) begin
            n_err++;
            $display("FAIL basic_start got %b want 110", {busy, in_ready, mem_enable});
        end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'(16'hA001 + i);
            tick();
            n_cmp++;
            if ({mem_enable, mem_write_enable, mem_read_enable, mem_address, mem_wdata} !== {3'b110, 15'(16 + i), 16'(16'hA001 + i)}) begin
                n_err++;
                $display("FAIL basic_wr%0d got %b/%h/%h want 110/%h/%h", i,
                         {mem_enable, mem_write_enable, mem_read_enable}, mem_address, mem_wdata, 15'(16 + i), 16'(16'hA001 + i));
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready, busy, done} !== 3'b010) begin
            n_err++;
            $display("FAIL basic_last got %b want 010", {in_ready, busy, done});
        end
        tick();
        n_cmp++;
        if ({done, busy, mem_enable} !== 3'b100) begin
            n_err++;
            $display("FAIL basic_done got %b want 100", {done, busy, mem_enable});
        end
        tick();
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_idle got %b want 00", {done, busy});
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[16 + i] !== 16'(16'hA001 + i)) begin
                n_err++;
                $display("FAIL basic_mem%0d got %h want %h", i, mem[16 + i], 16'(16'hA001 + i));
            end
        end
    endtask

    task automatic test_gaps();
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int beats = 0;
        int wr = 0;
        start_xfer(15'h0020, 16'd4);
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            in_data  = 16'(16'hB001 + beats);
            tick();
            n_cmp++;
            if (mem_enable !== pat[i] || mem_write_enable !== pat[i]) begin
                n_err++;
                $display("FAIL gaps_strobe%0d got %b%b want %b%b", i, mem_enable, mem_write_enable, pat[i], pat[i]);
            end
            if (mem_enable === 1'b1) wr++;
            if (pat[i]) begin
                n_cmp++;
                if ({mem_address, mem_wdata} !== {15'(32 + beats), 16'(16'hB001 + beats)}) begin
                    n_err++;
                    $display("FAIL gaps_wr%0d got %h/%h want %h/%h", beats, mem_address, mem_wdata, 15'(32 + beats), 16'(16'hB001 + beats));
                end
                beats++;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (wr !== 4) begin
            n_err++;
            $display("FAIL gaps_count got %0d want 4", wr);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL gaps_done got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [14:0] wa [3] = '{15'h7FFE, 15'h7FFF, 15'h0000};
        start_xfer(15'h7FFE, 16'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'(16'hC001 + i);
            tick();
            n_cmp++;
            if ({mem_enable, mem_address, mem_wdata} !== {1'b1, wa[i], 16'(16'hC001 + i)}) begin
                n_err++;
                $display("FAIL wrap_wr%0d got %b/%h/%h want 1/%h/%h", i, mem_enable, mem_address, mem_wdata, wa[i], 16'(16'hC001 + i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({done, mem[0]} !== {1'b1, 16'hC003}) begin
            n_err++;
            $display("FAIL wrap_done got %b/%h want 1/c003", done, mem[0]);
        end
        tick();
    endtask

    task automatic test_len0();
        start_xfer(15'h0300, 16'd0);
        n_cmp++;
        if ({busy, in_ready, mem_enable, done} !== 4'b1000) begin
            n_err++;
            $display("FAIL len0_busy got %b want 1000", {busy, in_ready, mem_enable, done});
        end
        tick();
        n_cmp++;
        if ({busy, in_ready, mem_enable, done} !== 4'b0001) begin
            n_err++;
            $display("FAIL len0_done got %b want 0001", {busy, in_ready, mem_enable, done});
        end
        tick();
        n_cmp++;
        if ({busy, in_ready, mem_enable, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL len0_idle got %b want 0000", {busy, in_ready, mem_enable, done});
        end
    endtask

    task automatic test_start_ignored();
        start_xfer(15'h0040, 16'd2);
        in_valid  = 1'b1;
        in_data   = 16'hD001;
        base_addr = 15'h0500;
        length    = 16'd9;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        n_cmp++;
        if ({mem_enable, mem_address, mem_wdata} !== {1'b1, 15'h0040, 16'hD001}) begin
            n_err++;
            $display("FAIL ign_wr0 got %b/%h/%h want 1/0040/d001", mem_enable, mem_address, mem_wdata);
        end
        in_data = 16'hD002;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({mem_enable, mem_address, mem_wdata, in_ready} !== {1'b1, 15'h0041, 16'hD002, 1'b0}) begin
            n_err++;
            $display("FAIL ign_wr1 got %b/%h/%h/%b want 1/0041/d002/0", mem_enable, mem_address, mem_wdata, in_ready);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if ({busy, in_ready, done} !== 3'b000) begin
            n_err++;
            $display("FAIL ign_idle got %b want 000", {busy, in_ready, done});
        end
    endtask

    task automatic test_reset_mid();
        start_xfer(15'h0060, 16'd5);
        in_valid = 1'b1;
        in_data  = 16'hE001;
        tick();
        in_data  = 16'hE002;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({mem_enable, mem_address, mem_wdata} !== {1'b1, 15'h0061, 16'hE002}) begin
            n_err++;
            $display("FAIL rmid_wr1 got %b/%h/%h want 1/0061/e002", mem_enable, mem_address, mem_wdata);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, mem_enable, mem_write_enable, mem_read_enable, busy, done, mismatch, mem_address, mem_wdata} !== 38'h0) begin
            n_err++;
            $display("FAIL rmid_async got %b/%h/%h want 0", {in_ready, mem_enable, mem_write_enable, mem_read_enable, busy, done, mismatch}, mem_address, mem_wdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_xfer(15'h0100, 16'd2);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 16'(16'hF001 + i);
            tick();
            n_cmp++;
            if ({mem_enable, mem_address, mem_wdata} !== {1'b1, 15'(256 + i), 16'(16'hF001 + i)}) begin
                n_err++;
                $display("FAIL rmid_new%0d got %b/%h/%h want 1/%h/%h", i, mem_enable, mem_address, mem_wdata, 15'(256 + i), 16'(16'hF001 + i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL rmid_done got %b want 10", {done, busy});
        end
        tick();
    endtask

    task automatic test_verify(input logic [15:0] d0, input logic [15:0] d1, input logic exp_mm);
        bit rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        start_xfer(15'h0200, 16'd2);
        in_valid = 1'b1;
        in_data  = d0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (in_ready !== rdy[i]) begin
                n_err++;
                $display("FAIL vfy_ready%0d got %b want %b", i, in_ready, rdy[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({mem_enable, mem_read_enable, mem_write_enable, mem_address} !== {3'b110, 15'h0200}) begin
                    n_err++;
                    $display("FAIL vfy_read got %b/%h want 110/0200", {mem_enable, mem_read_enable, mem_write_enable}, mem_address);
                end
            end
            if (i == 3) in_data = d1;
            if (i == 4) in_valid = 1'b0;
            tick();
        end
        tick();
        n_cmp++;
        if ({done, mismatch} !== {1'b1, exp_mm}) begin
            n_err++;
            $display("FAIL vfy_done got %b want %b", {done, mismatch}, {1'b1, exp_mm});
        end
        tick();
        tick();
        n_cmp++;
        if ({done, mismatch} !== {1'b0, exp_mm}) begin
            n_err++;
            $display("FAIL vfy_sticky got %b want %b", {done, mismatch}, {1'b0, exp_mm});
        end
    endtask

    initial begin
        test_reset();
`ifdef IMAGE_MEM_WRITER_VERIFY_EN
        test_verify(16'h1234, 16'h7777, 1'b1);
        test_verify(16'h5555, 16'h6666, 1'b0);
        test_reset_mid();
`else
        test_basic();
        test_gaps();
        test_wrap();
        test_len0();
        test_start_ignored();
        test_reset_mid();
        n_cmp++;
        if ({mismatch, mem_read_enable} !== 2'b00) begin
            n_err++;
            $display("FAIL noverify_tied got %b want 00", {mismatch, mem_read_enable});
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/image_mem_writer.md
Name: image_mem_writer

Overview:
- Write-side initiator for the image memory: takes a pixel stream over valid/ready and writes it to consecutive addresses starting at a programmable base.
- Drives the memory's enable / write_enable / read_enable / address / input_data pins directly.
- Sits between the pixel producer (loader or processing stage) and the image memory. It is the write counterpart of the read path that scans the image out.

Parameters:
- ADDR_W, 15, memory word-address width.
- DATA_W, 16, pixel/word width.
- LEN_W, ADDR_W+1, transfer-length counter width; allows a full 2^ADDR_W-word transfer.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on start.
- length  in  LEN_W  number of words to write; latched on start.
- in_valid  in  1  producer has a pixel.
- in_data  in  DATA_W  pixel word.
- in_ready  out  1  writer accepts the pixel this cycle.
- mem_enable  out  1  to memory enable.
- mem_write_enable  out  1  to memory write_enable.
- mem_read_enable  out  1  to memory read_enable.
- mem_address  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory input_data.
- mem_rdata  in  DATA_W  from memory output_data; used only with VERIFY_EN.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse at transfer end.
- mismatch  out  1  sticky readback-error flag; cleared on start.

Behaviour:
- States: IDLE, STREAM, DONE; with VERIFY_EN also VRD and VCMP.
- All outputs are registered.
- Reset values: every output 0, state IDLE, counters 0. Reset is asynchronous and may abort a transfer at any state; no partial write is held over.
- IDLE:
  - start=1 latches base_addr into the address pointer and length into the remaining counter, clears mismatch, and sets busy the next cycle.
  - If length==0, go to DONE; otherwise go to STREAM.
- STREAM:
  - in_ready=1. A handshake is in_valid & in_ready.
  - On a handshake, the next cycle presents mem_enable=1, mem_write_enable=1, mem_address=pointer, mem_wdata=in_data. Write latency is 1 cycle from handshake to the write strobe.
  - The pointer then increments and the remaining counter decrements. Back-to-back beats give one write per cycle.
  - The pointer wraps from 2^ADDR_W-1 to 0.
  - When the last beat is accepted (remaining==1), in_ready drops the following cycle and the state moves to DONE after that final write.
  - With no handshake, the write strobes are 0.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- start while busy is ignored. Data is never accepted outside STREAM/VRD-idle windows.
- mem_read_enable=0 always unless VERIFY_EN is defined.

Optional Feature:
- Macro: IMAGE_MEM_WRITER_VERIFY_EN.
- Defined: each write is followed by a readback.
  - STREAM (write cycle) -> VRD: mem_enable=1, mem_read_enable=1, same address.
  - VRD -> VCMP: compare mem_rdata against the held word. The memory has a registered 1-cycle read latency.
  - Any difference sets mismatch, which stays set until the next start.
  - in_ready=0 during VRD/VCMP, so throughput is one word per 3 cycles.
  - VCMP -> STREAM, or DONE after the final word.
- Undefined: no VRD/VCMP states exist, mismatch is tied 0, mem_read_enable is tied 0, and mem_rdata is unused.

Decomposition:
- Package image_mem_pkg holds:
  - the state enum (IDLE, STREAM, VRD, VCMP, DONE);
  - default ADDR_W=15 and DATA_W=16 constants shared with the image memory and the reader;
  - the memory request struct (enable, we, re, address, wdata).
- No sub-module is needed; the address/length counter lives inline in the FSM.

Test Plan:
- Basic: start, base=0x0010, length=4, data 0xA001..0xA004 streamed back-to-back -> writes at 0x0010..0x0013 on consecutive cycles; done pulses once; the memory then reads 0xA001..0xA004.
- Backpressure gaps: in_valid toggled 1,0,0,1,1,0,1 with length=4 -> exactly 4 write strobes, only in cycles following a handshake; no write during gaps.
- Wrap: base=0x7FFE, length=3 -> addresses 0x7FFE, 0x7FFF, 0x0000.
- Edge cases:
  - length=0 -> no write strobe; done one cycle after the following DONE state; busy high for one cycle.
  - start pulsed mid-transfer is ignored.
- Reset mid-transfer: rst_n low after 2 of 5 writes -> all outputs 0 immediately; a new start with base=0x0100, length=2 works normally.
- VERIFY_EN: force one memory word corrupt (0xBEEF stored instead of 0x1234) -> mismatch=1 after VCMP and stays set; a clean transfer gives mismatch=0; in_ready duty is 1 in 3.
